// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 8-bit accumulator CPU: decodes the opcode
// and Z flag and drives every datapath strobe as a decode of the registered state.
`timescale 1ns/1ps
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IrToCU,
    input  logic [4:0] DiToCU,
    input  logic [2:0] CznToCU,
    output logic       pcInc,
    output logic       pcLoadEn,
    output logic       diLoadEn,
    output logic       irWriteEn,
    output logic       trWriteEn,
    output logic       aRegWriteEn,
    output logic       bRegWriteEn,
    output logic       aluResWriteEn,
    output logic       accumulatorWriteEn,
    output logic       memoryWriteEn,
    output logic       ldCZN,
    output logic       PcOrTR,
    output logic       regOrMem,
    output logic       RegBOr0,
    output logic       RegAOr0,
    output logic       CC,
    output logic [1:0] aluOpControl,
    output logic [1:0] accAddressSel
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        ADDR   = 4'd3,
        BRANCH = 4'd4,
        MEMRD  = 4'd5,
        ACCRD  = 4'd6,
        EXEC   = 4'd7,
        WBACC  = 4'd8,
        WBMEM  = 4'd9
    } stateT;

    stateT state;
    stateT nextState;

    logic isSel;
    logic isRegOp;
    logic isJump;
    logic isJz;
    logic isStm;
    logic isLdm;
    logic isAnm;
    logic isMov;
    logic isAdc;
    logic isNot;

    // DI and the N/C flags are carried for the datapath only; the sequencer ignores them.
    logic unusedInputs;
    assign unusedInputs = ^{DiToCU, CznToCU[2], CznToCU[0]};

    assign isSel   = (IrToCU == 4'b1110);
    assign isMov   = (IrToCU == 4'b1100);
    assign isAdc   = (IrToCU == 4'b1101);
    assign isNot   = (IrToCU == 4'b1111);
    assign isRegOp = isMov | isAdc | isNot;
    assign isJump  = (IrToCU[3:2] == 2'b10);
    assign isJz    = (IrToCU[3:1] == 3'b101);
    assign isLdm   = (IrToCU[3:1] == 3'b000);
    assign isStm   = (IrToCU[3:1] == 3'b001);
    assign isAnm   = (IrToCU[3:1] == 3'b011);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   nextState = DECODE;
            DECODE: begin
                if (isSel)        nextState = FETCH;
                else if (isRegOp) nextState = ACCRD;
                else              nextState = ADDR;
            end
            ADDR: begin
                if (isJump)      nextState = BRANCH;
                else if (isStm)  nextState = ACCRD;
                else             nextState = MEMRD;
            end
            BRANCH:  nextState = FETCH;
            MEMRD:   nextState = EXEC;
            ACCRD:   nextState = EXEC;
            EXEC:    nextState = isStm ? WBMEM : WBACC;
            WBACC:   nextState = FETCH;
            WBMEM:   nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        pcInc              = 1'b0;
        pcLoadEn           = 1'b0;
        diLoadEn           = 1'b0;
        irWriteEn          = 1'b0;
        trWriteEn          = 1'b0;
        aRegWriteEn        = 1'b0;
        bRegWriteEn        = 1'b0;
        aluResWriteEn      = 1'b0;
        accumulatorWriteEn = 1'b0;
        memoryWriteEn      = 1'b0;
        ldCZN              = 1'b0;
        PcOrTR             = 1'b0;
        regOrMem           = 1'b0;
        RegBOr0            = 1'b0;
        RegAOr0            = 1'b0;
        CC                 = 1'b0;
        aluOpControl       = 2'b00;
        accAddressSel      = 2'b00;
        case (state)
            FETCH: begin
                PcOrTR    = 1'b1;
                irWriteEn = 1'b1;
                pcInc     = 1'b1;
            end
            DECODE: begin
                if (isSel) begin
                    diLoadEn = 1'b1;
                end else if (isRegOp) begin
                    accAddressSel = 2'b01;
                    aRegWriteEn   = 1'b1;
                end
            end
            ADDR: begin
                PcOrTR    = 1'b1;
                trWriteEn = 1'b1;
                pcInc     = 1'b1;
            end
            BRANCH: begin
                // JZ tests the Z flag left by the previous flag-setting instruction.
                pcLoadEn = isJump & (~isJz | CznToCU[1]);
            end
            MEMRD: begin
                bRegWriteEn   = 1'b1;
                aRegWriteEn   = 1'b1;
            end
            ACCRD: begin
                regOrMem      = 1'b1;
                bRegWriteEn   = 1'b1;
                accAddressSel = isRegOp ? 2'b10 : 2'b00;
            end
            EXEC: begin
                aluResWriteEn = 1'b1;
                ldCZN         = ~isStm;
                RegAOr0       = isLdm | isMov | isStm;
                CC            = isAdc;
                if (isAnm)      aluOpControl = 2'b01;
                else if (isNot) aluOpControl = 2'b10;
            end
            WBACC: begin
                accumulatorWriteEn = 1'b1;
                accAddressSel      = isRegOp ? 2'b01 : 2'b00;
            end
            WBMEM: begin
                memoryWriteEn = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
